// File: rtl/rr_decimal_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_decimal_arbiter_if
//
// Bundles the request/grant signals between up to ten requesters and the
// round-robin arbiter.
//
// Handshake: a requester raises req[i] and holds it for as long as it wants
// the shared resource. The arbiter answers with grant[i] (one-hot), the same
// owner as the binary grant_idx, and grant_valid. The owner keeps ownership
// while it holds req[i] and done is low. Ownership ends at the clock edge
// where done=1 is sampled, req[i] is sampled low, or the hold limit expires.
// A hold-limit release is flagged by a one-cycle timeout pulse. At least one
// cycle with grant_valid=0 always separates two owners.
//
//   req         requester -> arbiter  10  request vector, bit i = requester i
//   done        requester -> arbiter   1  current owner finished
//   grant       arbiter -> requester  10  one-hot grant, zero when no owner
//   grant_idx   arbiter -> requester   4  binary owner index, 0 when no owner
//   grant_valid arbiter -> requester   1  an owner holds the grant
//   timeout     arbiter -> requester   1  pulse: grant force-released
// ---------------------------------------------------------------------------
interface rr_decimal_arbiter_if;
    logic [9:0] req;
    logic       done;
    logic [9:0] grant;
    logic [3:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Requester side.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_decimal_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decimal_arbiter
//
// Round-robin arbiter that shares one downstream resource among NUM_REQ
// requesters (2..10). An owner keeps the grant until it signals done, drops
// its request, or has held it for MAX_HOLD cycles (1..255). The search for the
// next owner starts just after the previous owner, so the requester that just
// released has the lowest priority. All outputs are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   bus        rr_decimal_arbiter_if.slave: req/done in, grant/grant_idx/
//              grant_valid/timeout out
//   fsm_state  current controller state, 0 = IDLE, 1 = BUSY
// ---------------------------------------------------------------------------
module rr_decimal_arbiter #(
    parameter int NUM_REQ  = 10,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_decimal_arbiter_if.slave  bus,
    output logic                 fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requests at or above NUM_REQ are never considered.
    localparam logic [9:0] REQ_MASK = 10'((1 << NUM_REQ) - 1);

    state_t     state, state_next;
    logic [3:0] last_idx, last_idx_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic [9:0] grant_q, grant_next;
    logic [3:0] grant_idx_q, grant_idx_next;
    logic       grant_valid_q, grant_valid_next;
    logic       timeout_q, timeout_next;

    // Padding to 16 bits lets any 4-bit index address the vector safely.
    logic [15:0] req_ext;
    assign req_ext = {6'b0, bus.req & REQ_MASK};

    // ------------------------------------------------------------------
    // Rotating search: visit last_idx+1, last_idx+2, ... modulo NUM_REQ,
    // so the wrap goes from NUM_REQ-1 to 0 and never touches 10..15.
    // last_idx itself is visited last.
    // ------------------------------------------------------------------
    logic       found;
    logic [3:0] winner;
    logic [4:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_idx} + 5'(k);
            if (cand >= 5'(NUM_REQ)) begin
                cand = cand - 5'(NUM_REQ);
            end
            if (!found && req_ext[cand[3:0]]) begin
                found  = 1'b1;
                winner = cand[3:0];
            end
        end
    end

    // Release conditions for the current owner.
    logic rel_done, rel_drop, rel_hold;
    assign rel_done = bus.done;
    assign rel_drop = !req_ext[grant_idx_q];
    assign rel_hold = (hold_cnt == 8'(MAX_HOLD - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_idx      <= 4'(NUM_REQ - 1);
            hold_cnt      <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state         <= state_next;
            last_idx      <= last_idx_next;
            hold_cnt      <= hold_cnt_next;
            grant_q       <= grant_next;
            grant_idx_q   <= grant_idx_next;
            grant_valid_q <= grant_valid_next;
            timeout_q     <= timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        last_idx_next    = last_idx;
        hold_cnt_next    = hold_cnt;
        grant_next       = grant_q;
        grant_idx_next   = grant_idx_q;
        grant_valid_next = grant_valid_q;
        timeout_next     = 1'b0;

        case (state)
            IDLE: begin
                // done is deliberately not looked at here.
                if (found) begin
                    state_next       = BUSY;
                    grant_next       = 10'd1 << winner;
                    grant_idx_next   = winner;
                    grant_valid_next = 1'b1;
                    last_idx_next    = winner;
                    hold_cnt_next    = '0;
                end else begin
                    grant_next       = '0;
                    grant_idx_next   = '0;
                    grant_valid_next = 1'b0;
                end
            end

            BUSY: begin
                // Other requesters wait; they are arbitrated in the IDLE
                // cycle that always follows a release.
                if (rel_done || rel_drop || rel_hold) begin
                    state_next       = IDLE;
                    grant_next       = '0;
                    grant_idx_next   = '0;
                    grant_valid_next = 1'b0;
                    // Only a release caused purely by the hold limit counts
                    // as a timeout.
                    timeout_next     = rel_hold && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;
    assign fsm_state       = (state == BUSY);

endmodule

// File: tb/tb_rr_decimal_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decimal_arbiter
//
// Two arbiters run side by side from the same request/done stimulus:
//   unit 0: NUM_REQ=10, MAX_HOLD=8
//   unit 1: NUM_REQ=6,  MAX_HOLD=3
// A cycle-level reference model (integer owner, modulo search) predicts the
// outputs of both after every clock edge.
// ---------------------------------------------------------------------------
module tb_rr_decimal_arbiter;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_decimal_arbiter_if bus0 ();
    rr_decimal_arbiter_if bus6 ();
    logic st0, st6;

    rr_decimal_arbiter #(.NUM_REQ(10), .MAX_HOLD(8)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .fsm_state (st0)
    );

    rr_decimal_arbiter #(.NUM_REQ(6), .MAX_HOLD(3)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus6),
        .fsm_state (st6)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int   u_n  [2] = '{10, 6};
    int   u_mh [2] = '{8, 3};
    int   m_owner [2];   // -1 = no owner
    int   m_last  [2];
    int   m_hold  [2];   // cycles already held beyond the first
    logic m_to    [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_last[u]  = u_n[u] - 1;
            m_hold[u]  = 0;
            m_to[u]    = 1'b0;
        end
    endtask

    task automatic model_tick(input int u, input logic [9:0] r, input logic d);
        int  n;
        bit  by_done, by_drop, by_hold;
        n = u_n[u];
        m_to[u] = 1'b0;
        if (m_owner[u] < 0) begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (m_last[u] + k) % n;
                if (m_owner[u] < 0 && r[c]) begin
                    m_owner[u] = c;
                    m_last[u]  = c;
                    m_hold[u]  = 0;
                end
            end
        end else begin
            by_done = d;
            by_drop = !r[m_owner[u]];
            by_hold = (m_hold[u] == u_mh[u] - 1);
            if (by_done || by_drop || by_hold) begin
                m_to[u]    = by_hold && !by_done && !by_drop;
                m_owner[u] = -1;
            end else begin
                m_hold[u] = m_hold[u] + 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_unit(input int u, input logic [9:0] g, input logic [3:0] gi,
                              input logic gv, input logic to, input logic st);
        logic [9:0] eg;
        logic [3:0] ei;
        eg = '0;
        ei = '0;
        if (m_owner[u] >= 0) begin
            eg = 10'd1 << m_owner[u];
            ei = 4'(m_owner[u]);
        end
        check_eq($sformatf("u%0d.grant", u),       32'(g),  32'(eg));
        check_eq($sformatf("u%0d.grant_idx", u),   32'(gi), 32'(ei));
        check_eq($sformatf("u%0d.grant_valid", u), 32'(gv), 32'(m_owner[u] >= 0));
        check_eq($sformatf("u%0d.timeout", u),     32'(to), 32'(m_to[u]));
        check_eq($sformatf("u%0d.fsm_state", u),   32'(st), 32'(m_owner[u] >= 0));
    endtask

    task automatic check_all();
        check_unit(0, bus0.grant, bus0.grant_idx, bus0.grant_valid, bus0.timeout, st0);
        check_unit(1, bus6.grant, bus6.grant_idx, bus6.grant_valid, bus6.timeout, st6);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive, let one rising edge pass, check at the
    // next falling edge.
    task automatic step(input logic [9:0] r, input logic d);
        bus0.req  = r;
        bus0.done = d;
        bus6.req  = r;
        bus6.done = d;
        @(posedge clk);
        model_tick(0, r, d);
        model_tick(1, r, d);
        @(negedge clk);
        check_all();
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [9:0] rnd_req;
    logic       rnd_done;

    initial begin
        bus0.req = '0; bus0.done = 1'b0;
        bus6.req = '0; bus6.done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Reset in the middle of a grant, then re-grant.
        step(10'h008, 1'b0);
        step(10'h008, 1'b0);
        check_eq("mid.grant_idx", 32'(bus0.grant_idx), 32'd3);
        async_reset();
        check_eq("rst.grant_valid", 32'(bus0.grant_valid), 32'd0);
        step(10'h008, 1'b0);
        check_eq("rst.regrant", 32'(bus0.grant), 32'h008);
        check_eq("rst.regrant_idx", 32'(bus0.grant_idx), 32'd3);
        step(10'h000, 1'b0);

        // Round-robin rotation with done one cycle after each grant.
        async_reset();
        for (int k = 0; k < 11; k++) begin
            step(10'h3FF, 1'b0);
            check_eq("rot.grant_idx", 32'(bus0.grant_idx), 32'(k % 10));
            step(10'h3FF, 1'b1);
            check_eq("rot.gap", 32'(bus0.grant_valid), 32'd0);
        end

        // Wrap-around and pointer priority.
        step(10'h200, 1'b0);
        check_eq("wrap.owner9", 32'(bus0.grant_idx), 32'd9);
        step(10'h000, 1'b0);
        step(10'h201, 1'b0);
        check_eq("wrap.to0", 32'(bus0.grant_idx), 32'd0);
        step(10'h201, 1'b1);
        step(10'h201, 1'b0);
        check_eq("wrap.to9", 32'(bus0.grant_idx), 32'd9);
        step(10'h000, 1'b0);

        // Timeout on a held request, then re-grant after one idle cycle.
        step(10'h020, 1'b0);
        check_eq("to.first", 32'(bus0.grant_idx), 32'd5);
        for (int i = 1; i < 8; i++) begin
            step(10'h020, 1'b0);
            check_eq("to.held", 32'(bus0.grant_valid), 32'd1);
        end
        step(10'h020, 1'b0);
        check_eq("to.pulse", 32'(bus0.timeout), 32'd1);
        check_eq("to.released", 32'(bus0.grant_valid), 32'd0);
        step(10'h020, 1'b0);
        check_eq("to.pulse_end", 32'(bus0.timeout), 32'd0);
        check_eq("to.regrant", 32'(bus0.grant_idx), 32'd5);

        // Last hold cycle: done and request drop together -> no timeout.
        for (int i = 1; i < 8; i++) begin
            step(10'h020, 1'b0);
        end
        step(10'h000, 1'b1);
        check_eq("sim.timeout", 32'(bus0.timeout), 32'd0);
        check_eq("sim.released", 32'(bus0.grant_valid), 32'd0);

        // NUM_REQ=6 unit ignores requesters 6..9.
        for (int i = 0; i < 5; i++) begin
            step(10'h3C0, 1'b0);
            check_eq("n6.none", 32'(bus6.grant_valid), 32'd0);
        end
        step(10'h000, 1'b0);
        step(10'h3E0, 1'b0);
        check_eq("n6.grant", 32'(bus6.grant), 32'h020);
        check_eq("n6.grant_idx", 32'(bus6.grant_idx), 32'd5);

        // Random traffic, requests mostly held so grants persist.
        rnd_req = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd_req = 10'($urandom & $urandom);
            end
            rnd_done = ($urandom_range(0, 4) == 0);
            if (i == 200) begin
                async_reset();
            end
            step(rnd_req, rnd_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_decimal_arbiter.md
# rr_decimal_arbiter

Round-robin arbiter sharing one downstream resource (e.g. the BCD/display datapath fed by the decimal-to-binary encoder) among up to ten requesters. Each requester owns one bit of a one-hot-style request vector. The arbiter grants exactly one requester at a time, holds the grant until release or timeout, and presents the winner both as a one-hot grant vector and as a 4-bit binary index (0–9). One idle cycle always separates consecutive owners.

## Interface
- NUM_REQ, default 10: number of active requesters, legal 2..10; req/grant bits at or above NUM_REQ are ignored and driven 0.
- MAX_HOLD, default 8: maximum cycles an owner may hold the grant, legal 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  10  request vector; bit i = requester i wants the resource; any number of bits may be set.
- done  input  1  current owner finished; sampled only in BUSY.
- grant  output  10  one-hot grant, all-zero when no owner.
- grant_idx  output  4  binary index of owner, 4'd0 when no owner.
- grant_valid  output  1  high while an owner holds the grant.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- State machine, two states: IDLE (no owner), BUSY (owner held). Reset state IDLE.
- Priority pointer last_idx (4 bits) = index of most recent owner; reset value NUM_REQ-1 so first search starts at index 0.
- IDLE: scan masked req (bits < NUM_REQ) starting at last_idx+1, wrapping NUM_REQ-1 → 0 (never through 10..15); first set bit wins. If found: register grant/grant_idx/grant_valid, last_idx <= winner, hold_cnt <= 0, go BUSY. If none: stay IDLE, outputs 0.
- BUSY release conditions, evaluated each cycle: (a) done=1; (b) req[owner]=0; (c) hold_cnt = MAX_HOLD-1. Any true → clear grant, grant_idx, grant_valid next edge, go IDLE. Otherwise hold_cnt increments (8-bit, never wraps since bounded by MAX_HOLD).
- timeout pulses only for release by (c) alone; if (a) or (b) is also true that cycle, timeout stays 0.
- Requests from non-owners during BUSY are ignored; they are arbitrated in the following IDLE cycle.
- Pointer fairness: a requester that just released is lowest priority in the next scan; a sole requester may be re-granted after the mandatory idle cycle.
- grant and grant_idx always agree (grant = 1 << grant_idx when grant_valid=1; both zero otherwise).

## Timing
- All outputs registered; reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, last_idx=NUM_REQ-1, hold_cnt=0, state IDLE.
- Grant latency: req sampled at edge E in IDLE → grant visible after edge E (1 cycle).
- Hold: owner granted at edge E sees grant for at most MAX_HOLD cycles; with MAX_HOLD=8 and no done, grant drops after edge E+8, timeout high for the cycle following that edge.
- Release: done sampled high at edge R → grant 0 after R; next owner (if any) granted after R+1. Minimum owner-to-owner gap: exactly one cycle.
- done sampled while IDLE has no effect.
- rst_n low at any time (including mid-BUSY): all outputs go to reset values immediately, independent of clk; operation resumes at first clk edge after rst_n deassertion, starting in IDLE.

## Test plan
- Reset mid-grant: owner 3 in BUSY, pull rst_n low between edges → grant=0, grant_idx=0, grant_valid=0 without clock edge; after release req=10'h008 → grant=10'h008, grant_idx=4'd3 one cycle later.
- Round-robin rotation: req=10'h3FF held, done pulsed one cycle after each grant → grant_idx sequence 0,1,...,9,0 with exactly one idle cycle between owners.
- Wrap and pointer: last owner 9, req=10'h201 → next grant idx 0; then last owner 0, req=10'h201 → grant idx 9.
- Timeout: MAX_HOLD=8, req=10'h020 held, done=0 → grant_idx=5 for 8 cycles, timeout=1 for one cycle, grant_valid=0 next cycle, re-grant idx 5 one cycle later.
- Simultaneous release: on the last hold cycle assert done=1 and drop req[owner] together → single release, timeout stays 0.
- NUM_REQ=6: req=10'h3C0 only → no grant ever; req=10'h3E0 → grant_idx=5 only.
